// File: rtl/uart_io_bridge_if.sv
// uart_io_bridge_if: CPU data-memory port plus UART byte handshakes for uart_io_bridge.
// The slave modport is the bridge side. The master modport is the CPU/UART side.
interface uart_io_bridge_if;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        io_sel;
    logic [31:0] rdata;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;

    modport slave (
        input  stall, addr, wdata, we, re, uart_din_ready, uart_dout, uart_dout_valid,
        output io_sel, rdata, uart_din, uart_din_valid, uart_dout_ready
    );

    modport master (
        output stall, addr, wdata, we, re, uart_din_ready, uart_dout, uart_dout_valid,
        input  io_sel, rdata, uart_din, uart_din_valid, uart_dout_ready
    );
endinterface

// File: rtl/uart_io_bridge.sv
// uart_io_bridge: memory-mapped bridge from the CPU data port (0x8xxx_xxxx) to the UART.
// It has RX/TX byte FIFOs, a status register, and a free-running cycle counter.
// Optional feature macro UART_IO_OVERFLOW_CNT_EN adds a saturating RX-drop counter at index 4.
module uart_io_bridge #(
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_io_bridge_if.slave  bus
);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);

    logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [31:0]    cyc_q, cyc_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    rd_mux;

    logic       take, rd, wr;
    logic [2:0] idx;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, tx_push, tx_pop;
    logic       tx_valid;
    logic       ovf_nz;
    logic       unused_bits;

    assign unused_bits = ^{bus.addr[27:5], bus.addr[1:0], bus.wdata[31:8]};

    // Address decode and access qualification.
    assign bus.io_sel = (bus.addr[31:28] == 4'h8);
    assign take       = bus.io_sel && !bus.stall && (bus.re || (bus.we != 4'b0000));
    assign rd         = take && bus.re;
    assign wr         = take && (bus.we != 4'b0000);
    assign idx        = bus.addr[4:2];

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);

    assign rx_pop  = rd && (idx == 3'd1) && !rx_empty;
    assign rx_push = bus.uart_dout_valid && (!rx_full || rx_pop);
    // The TX push checks the full flag from the start of the cycle, so a same-cycle pop does not make room.
    assign tx_push = wr && (idx == 3'd2) && !tx_full;
    // Gating with rst drops valid in the reset cycle itself.
    assign tx_valid = !tx_empty && rst;
    assign tx_pop   = tx_valid && bus.uart_din_ready;

    assign bus.uart_din_valid  = tx_valid;
    assign bus.uart_din        = tx_valid ? tx_mem_q[tx_rd_q[TX_AW-1:0]] : 8'h00;
    assign bus.uart_dout_ready = rst;
    assign bus.rdata           = rdata_q;

`ifdef UART_IO_OVERFLOW_CNT_EN
    logic [31:0] ovf_q, ovf_d;
    logic        rx_drop;

    assign rx_drop = bus.uart_dout_valid && rx_full && !rx_pop;
    assign ovf_nz  = (ovf_q != '0);

    // Next value of the overflow counter: a write clears it; otherwise it saturates on each dropped byte.
    always_comb begin
        ovf_d = ovf_q;
        if (wr && (idx == 3'd4))
            ovf_d = '0;
        else if (rx_drop && (ovf_q != '1))
            ovf_d = ovf_q + 32'd1;
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (!rst) ovf_q <= '0;
        else      ovf_q <= ovf_d;
    end
`else
    assign ovf_nz = 1'b0;
`endif

    // Load-data mux. Status reflects state before this cycle's push/pop.
    always_comb begin
        rd_mux = '0;
        case (idx)
            3'd0: rd_mux = {29'b0, ovf_nz, !tx_full, !rx_empty};
            3'd1: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem_q[rx_rd_q[RX_AW-1:0]]};
            3'd3: rd_mux = cyc_q;
`ifdef UART_IO_OVERFLOW_CNT_EN
            3'd4: rd_mux = ovf_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    // Next-state for the pointers, the cycle counter and the load data.
    always_comb begin
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;
        tx_wr_d = tx_wr_q;
        tx_rd_d = tx_rd_q;
        rdata_d = rdata_q;
        cyc_d   = cyc_q + 32'd1;
        if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
        if (wr && (idx == 3'd3)) cyc_d = '0;
        if (rd) rdata_d = rd_mux;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            cyc_q   <= '0;
            rdata_q <= '0;
        end else begin
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
        end
    end

    // FIFO storage writes. Contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst && rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= bus.uart_dout;
        if (rst && tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= bus.wdata[7:0];
    end
endmodule
